vdp_port_ctrl: RTL and testbench

VDP_PORT_CTRL -- requirements
Module: vdp_port_ctrl

---
 rtl/vdp_pkg.sv | 26 ++
 rtl/vdp_wfifo.sv | 56 +++++
 rtl/vdp_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_vdp_port_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP control/data port front end.
package vdp_pkg;

   typedef enum logic [1:0] {
      VRAM  = 2'd0,
      CRAM  = 2'd1,
      VSRAM = 2'd2
   } vdp_target_e;

   // Low four code bits that select a write target.
   localparam logic [3:0] CODE_VRAM_WR  = 4'b0001;
   localparam logic [3:0] CODE_CRAM_WR  = 4'b0011;
   localparam logic [3:0] CODE_VSRAM_WR = 4'b0101;

   localparam logic [1:0] CTRL_REG_WR   = 2'b10;
   localparam logic [4:0] AUTOINC_REG   = 5'd15;
   localparam logic [7:0] AUTOINC_RESET = 8'd2;
   localparam int         FIFO_DEPTH    = 4;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      vdp_target_e target;
   } vdp_wentry_t;

endpackage

// File: rtl/vdp_wfifo.sv
// Write FIFO: head entry is visible on dout the cycle after it is pushed.
module vdp_wfifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [33:0]
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t din,
   input  logic   pop,
   output entry_t dout,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)
            count <= count + CNT_W'(1);
         else if (!do_push && do_pop)
            count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vdp_port_ctrl.sv
// VDP control/data port decoder feeding a write FIFO toward VRAM/CRAM/VSRAM.
// Define VDP_AUTOINC_EN to take the address increment from register 15.
module vdp_port_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_wr,
   input  logic [15:0] ctrl_in,
   input  logic        data_wr,
   input  logic [15:0] data_in,
   input  logic        vram_ready,
   output logic        vram_wr,
   output logic [15:0] vram_addr,
   output logic [15:0] vram_wdata,
   output logic [1:0]  vram_target,
   output logic        reg_wr,
   output logic [4:0]  reg_idx,
   output logic [7:0]  reg_data,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        cmd_pending,
   output logic        err
);
   import vdp_pkg::*;

   typedef enum logic {IDLE, HALF} state_e;

   state_e      state_q, state_d;
   // Code bits 5:4 never influence the write path, so only 3:0 are kept.
   logic [3:0]  code_q, code_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  inc;
   logic        reg_hit;
   logic        push;
   logic        pop;
   logic        drop;
   logic        tgt_ok;
   vdp_target_e tgt;
   vdp_wentry_t push_entry;
   vdp_wentry_t head;

`ifdef VDP_AUTOINC_EN
   logic [7:0] inc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         inc_q <= AUTOINC_RESET;
      else if (reg_hit && ctrl_in[12:8] == AUTOINC_REG)
         inc_q <= ctrl_in[7:0];
   end

   assign inc = inc_q;
`else
   assign inc = AUTOINC_RESET;
`endif

   always_comb begin
      tgt    = VRAM;
      tgt_ok = 1'b1;
      case (code_q)
         CODE_VRAM_WR:  tgt = VRAM;
         CODE_CRAM_WR:  tgt = CRAM;
         CODE_VSRAM_WR: tgt = VSRAM;
         default:       tgt_ok = 1'b0;
      endcase
   end

   assign pop = vram_wr && vram_ready;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      addr_d  = addr_q;
      reg_hit = 1'b0;
      push    = 1'b0;
      drop    = 1'b0;
      if (ctrl_wr) begin
         if (state_q == IDLE) begin
            if (ctrl_in[15:14] == CTRL_REG_WR) begin
               reg_hit = 1'b1;
            end else begin
               code_d[1:0]  = ctrl_in[15:14];
               addr_d[13:0] = ctrl_in[13:0];
               state_d      = HALF;
            end
         end else begin
            code_d[3:2]   = ctrl_in[5:4];
            addr_d[15:14] = ctrl_in[1:0];
            state_d       = IDLE;
         end
         // The control port wins a collision; the data word is lost.
         drop = data_wr;
      end else if (data_wr) begin
         state_d = IDLE;
         if (tgt_ok) begin
            if (!fifo_full || pop) begin
               push   = 1'b1;
               addr_d = addr_q + {8'h00, inc};
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         code_q   <= '0;
         addr_q   <= '0;
         reg_wr   <= 1'b0;
         reg_idx  <= '0;
         reg_data <= '0;
         err      <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         addr_q  <= addr_d;
         reg_wr  <= reg_hit;
         if (reg_hit) begin
            reg_idx  <= ctrl_in[12:8];
            reg_data <= ctrl_in[7:0];
         end
         if (drop) err <= 1'b1;
      end
   end

   assign push_entry = '{addr: addr_q, data: data_in, target: tgt};

   vdp_wfifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (vdp_wentry_t)
   ) u_wfifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign vram_wr     = !fifo_empty;
   assign vram_addr   = head.addr;
   assign vram_wdata  = head.data;
   assign vram_target = head.target;
   assign cmd_pending = (state_q == HALF);

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Randomized and directed bench for vdp_port_ctrl against a queue-based model.
module tb_vdp_port_ctrl;

`ifdef VDP_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif
   localparam logic [15:0] EXP_INC = AUTOINC ? 16'd4 : 16'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctrl_wr, data_wr, vram_ready;
   logic [15:0] ctrl_in, data_in;
   logic        vram_wr;
   logic [15:0] vram_addr, vram_wdata;
   logic [1:0]  vram_target;
   logic        reg_wr;
   logic [4:0]  reg_idx;
   logic [7:0]  reg_data;
   logic        fifo_full, fifo_empty, cmd_pending, err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vdp_port_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl_wr     (ctrl_wr),
      .ctrl_in     (ctrl_in),
      .data_wr     (data_wr),
      .data_in     (data_in),
      .vram_ready  (vram_ready),
      .vram_wr     (vram_wr),
      .vram_addr   (vram_addr),
      .vram_wdata  (vram_wdata),
      .vram_target (vram_target),
      .reg_wr      (reg_wr),
      .reg_idx     (reg_idx),
      .reg_data    (reg_data),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .cmd_pending (cmd_pending),
      .err         (err)
   );

   // Reference model: plain integers and a queue of pending writes.
   typedef struct {
      int unsigned addr;
      int unsigned data;
      int unsigned tgt;
   } ent_t;

   ent_t        mq[$];
   bit          m_pend, m_err, m_regwr;
   int unsigned m_idx, m_rdata, m_code, m_addr, m_inc;

   task automatic model_reset();
      mq.delete();
      m_pend = 0; m_err = 0; m_regwr = 0;
      m_idx = 0; m_rdata = 0; m_code = 0; m_addr = 0; m_inc = 2;
   endtask

   task automatic model_step(input bit cw, input int unsigned ci, input bit dw,
                             input int unsigned di, input bit rdy);
      bit pop;
      int tgt;
      pop = (mq.size() > 0) && rdy;
      m_regwr = 0;
      if (cw) begin
         if (!m_pend && ((ci >> 14) == 2)) begin
            m_regwr = 1;
            m_idx   = (ci >> 8) & 'h1F;
            m_rdata = ci & 'hFF;
            if (AUTOINC && m_idx == 15) m_inc = m_rdata;
         end else if (!m_pend) begin
            m_code = (m_code & 'h3C) | (ci >> 14);
            m_addr = (m_addr & 'hC000) | (ci & 'h3FFF);
            m_pend = 1;
         end else begin
            m_code = (m_code & 'h3) | (((ci >> 4) & 'hF) << 2);
            m_addr = (m_addr & 'h3FFF) | ((ci & 'h3) << 14);
            m_pend = 0;
         end
         if (dw) m_err = 1;
         if (pop) void'(mq.pop_front());
      end else begin
         case (m_code & 'hF)
            1:       tgt = 0;
            3:       tgt = 1;
            5:       tgt = 2;
            default: tgt = -1;
         endcase
         if (dw) m_pend = 0;
         if (dw && tgt >= 0 && (mq.size() < 4 || pop)) begin
            if (pop) void'(mq.pop_front());
            mq.push_back('{addr: m_addr, data: di, tgt: tgt});
            m_addr = (m_addr + m_inc) % 65536;
         end else begin
            if (dw && tgt >= 0) m_err = 1;
            if (pop) void'(mq.pop_front());
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("vram_wr", vram_wr, mq.size() != 0);
      chk("fifo_empty", fifo_empty, mq.size() == 0);
      chk("fifo_full", fifo_full, mq.size() == 4);
      chk("vram_addr", vram_addr, mq.size() ? mq[0].addr : 0);
      chk("vram_wdata", vram_wdata, mq.size() ? mq[0].data : 0);
      chk("vram_target", vram_target, mq.size() ? mq[0].tgt : 0);
      chk("cmd_pending", cmd_pending, m_pend);
      chk("err", err, m_err);
      chk("reg_wr", reg_wr, m_regwr);
      chk("reg_idx", reg_idx, m_idx);
      chk("reg_data", reg_data, m_rdata);
   endtask

   task automatic step(input bit cw, input logic [15:0] ci, input bit dw,
                       input logic [15:0] di, input bit rdy);
      ctrl_wr = cw; ctrl_in = ci; data_wr = dw; data_in = di; vram_ready = rdy;
      model_step(cw, ci, dw, di, rdy);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      ctrl_wr = 0; data_wr = 0; ctrl_in = 0; data_in = 0; vram_ready = 0;
      rst = 1;
      #2;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst = 0;
   endtask

   initial begin
      logic [15:0] ci;
      rst = 1;
      ctrl_wr = 0; data_wr = 0; ctrl_in = 0; data_in = 0; vram_ready = 0;
      model_reset();
      #2;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 0;

      // Command then two data writes drained immediately.
      step(1, 16'h4000, 0, 0, 1);
      step(1, 16'h0000, 0, 0, 1);
      step(0, 0, 1, 16'hABCD, 1);
      chk("t41_addr0", vram_addr, 16'h0000);
      chk("t41_data0", vram_wdata, 16'hABCD);
      chk("t41_tgt0", vram_target, 2'd0);
      step(0, 0, 1, 16'h1234, 1);
      chk("t41_addr1", vram_addr, 16'h0002);
      chk("t41_data1", vram_wdata, 16'h1234);
      step(0, 0, 0, 0, 1);
      chk("t41_empty", fifo_empty, 1'b1);

      // CRAM writes wrapping past FFFF.
      do_reset();
      step(1, 16'hFFFE, 0, 0, 1);
      step(1, 16'h0003, 0, 0, 1);
      step(0, 0, 1, 16'h0111, 1);
      chk("t42_addr0", vram_addr, 16'hFFFE);
      chk("t42_tgt0", vram_target, 2'd1);
      step(0, 0, 1, 16'h0222, 1);
      chk("t42_wrap", vram_addr, 16'h0000);
      step(0, 0, 0, 0, 1);

      // Back-pressure: four queued, fifth dropped, then drained in order.
      do_reset();
      step(1, 16'h4000, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h1000 + 16'(i), 0);
      chk("t43_full", fifo_full, 1'b1);
      chk("t43_err", err, 1'b1);
      chk("t43_head", vram_addr, 16'h0000);
      for (int i = 1; i < 4; i++) begin
         step(0, 0, 0, 0, 1);
         chk("t43_order", vram_wdata, 16'h1000 + 16'(i));
      end
      step(0, 0, 0, 0, 1);
      chk("t43_drained", fifo_empty, 1'b1);

      // Pending half cleared by data; reset while in HALF with queued data.
      do_reset();
      step(1, 16'h4000, 0, 0, 0);
      chk("t44_pend1", cmd_pending, 1'b1);
      step(0, 0, 1, 16'h5555, 0);
      chk("t44_pend0", cmd_pending, 1'b0);
      step(1, 16'h4000, 0, 0, 0);
      do_reset();
      chk("t44_empty", fifo_empty, 1'b1);
      chk("t44_vram_wr", vram_wr, 1'b0);

      // Register 15 write and the resulting increment.
      step(1, 16'h8F04, 0, 0, 0);
      chk("t40_reg_wr", reg_wr, 1'b1);
      chk("t40_idx", reg_idx, 5'd15);
      chk("t40_data", reg_data, 8'h04);
      step(1, 16'h4000, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0);
      step(0, 0, 1, 16'hAAAA, 0);
      step(0, 0, 1, 16'hBBBB, 0);
      step(0, 0, 0, 0, 1);
      chk("t40_inc", vram_addr, EXP_INC);
      step(0, 0, 0, 0, 1);

      // Collision: control wins, data dropped.
      do_reset();
      step(1, 16'h4000, 1, 16'h7777, 0);
      chk("coll_err", err, 1'b1);
      chk("coll_empty", fifo_empty, 1'b1);

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            ci = 16'($urandom);
            if ($urandom_range(0, 1) != 0) ci[5:4] = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ci[15:14] = 2'b01;
            step($urandom_range(0, 5) == 0, ci, $urandom_range(0, 2) == 0,
                 16'($urandom), $urandom_range(0, 1) == 1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
